// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - condition-code enum, CCR flag positions and DBcc state encoding
package ccr_pkg;

    localparam int unsigned CCR_W = 5;

    localparam int unsigned X_BIT = 4;
    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned V_BIT = 1;
    localparam int unsigned C_BIT = 0;

    typedef enum logic [3:0] {
        CC_T  = 4'd0,
        CC_F  = 4'd1,
        CC_HI = 4'd2,
        CC_LS = 4'd3,
        CC_CC = 4'd4,
        CC_CS = 4'd5,
        CC_NE = 4'd6,
        CC_EQ = 4'd7,
        CC_VC = 4'd8,
        CC_VS = 4'd9,
        CC_PL = 4'd10,
        CC_MI = 4'd11,
        CC_GE = 4'd12,
        CC_LT = 4'd13,
        CC_GT = 4'd14,
        CC_LE = 4'd15
    } cc_cond_e;

    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_EVAL = 1'b1
    } dbcc_state_e;

endpackage

// File: rtl/ccr_cond_eval.sv
// rtl/ccr_cond_eval.sv - combinational 68k condition decode over N,Z,V,C (nzvc[3:0]); cond in, cond_true out
module ccr_cond_eval
    import ccr_pkg::*;
(
    input  logic [3:0] nzvc,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic f_n;
    logic f_z;
    logic f_v;
    logic f_c;

    assign f_n = nzvc[N_BIT];
    assign f_z = nzvc[Z_BIT];
    assign f_v = nzvc[V_BIT];
    assign f_c = nzvc[C_BIT];

    always_comb begin
        cond_true = 1'b0;
        case (cc_cond_e'(cond))
            CC_T:    cond_true = 1'b1;
            CC_F:    cond_true = 1'b0;
            CC_HI:   cond_true = !f_c && !f_z;
            CC_LS:   cond_true = f_c || f_z;
            CC_CC:   cond_true = !f_c;
            CC_CS:   cond_true = f_c;
            CC_NE:   cond_true = !f_z;
            CC_EQ:   cond_true = f_z;
            CC_VC:   cond_true = !f_v;
            CC_VS:   cond_true = f_v;
            CC_PL:   cond_true = !f_n;
            CC_MI:   cond_true = f_n;
            CC_GE:   cond_true = (f_n == f_v);
            CC_LT:   cond_true = (f_n != f_v);
            CC_GT:   cond_true = !f_z && (f_n == f_v);
            CC_LE:   cond_true = f_z || (f_n != f_v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - CCR register, cond_true decode and DBcc loop counter (DBcc present only with CCR_DBCC_EN)
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_c,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_n,
    input  logic                upd_valid,
    input  logic [4:0]          upd_mask,
    input  logic                z_sticky,
    input  logic                ccr_wr,
    input  logic [4:0]          ccr_wdata,
    input  logic [3:0]          cond,
    output logic [4:0]          ccr,
    output logic                cond_true,
    input  logic                dbcc_load,
    input  logic [CNT_BITS-1:0] dbcc_init,
    input  logic                dbcc_go,
    input  logic [3:0]          dbcc_cond,
    output logic                dbcc_done,
    output logic                dbcc_branch,
    output logic [CNT_BITS-1:0] dbcc_count
);

    logic [CCR_W-1:0] ccr_q;
    logic [CCR_W-1:0] ccr_d;

    always_comb begin
        ccr_d = ccr_q;
        if (ccr_wr) begin
            ccr_d = ccr_wdata;
        end else if (upd_valid) begin
            if (upd_mask[X_BIT]) ccr_d[X_BIT] = alu_c;
            if (upd_mask[N_BIT]) ccr_d[N_BIT] = alu_n;
            // Extended-precision ops accumulate Z across words: it can only be cleared.
            if (upd_mask[Z_BIT]) ccr_d[Z_BIT] = z_sticky ? (ccr_q[Z_BIT] & alu_z) : alu_z;
            if (upd_mask[V_BIT]) ccr_d[V_BIT] = alu_v;
            if (upd_mask[C_BIT]) ccr_d[C_BIT] = alu_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q <= '0;
        end else begin
            ccr_q <= ccr_d;
        end
    end

    assign ccr = ccr_q;

    ccr_cond_eval u_cond_eval (
        .nzvc      (ccr_q[3:0]),
        .cond      (cond),
        .cond_true (cond_true)
    );

`ifdef CCR_DBCC_EN

    dbcc_state_e         state_q;
    dbcc_state_e         state_d;
    logic [3:0]          dcond_q;
    logic [3:0]          dcond_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic                step_true;
    logic                branch_d;

    // Evaluated against ccr_q in the EVAL cycle, so a flag update landing
    // on the same edge as dbcc_go is already visible here.
    ccr_cond_eval u_dbcc_eval (
        .nzvc      (ccr_q[3:0]),
        .cond      (dcond_q),
        .cond_true (step_true)
    );

    always_comb begin
        state_d  = state_q;
        dcond_d  = dcond_q;
        cnt_d    = cnt_q;
        branch_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (dbcc_go) begin
                    dcond_d = dbcc_cond;
                    state_d = DB_EVAL;
                end
            end
            DB_EVAL: begin
                state_d = DB_IDLE;
                if (!step_true) begin
                    cnt_d    = cnt_q - CNT_BITS'(1);
                    // Falling through happens when the decrement wraps 0 -> all-ones.
                    branch_d = (cnt_q != '0);
                end
            end
            default: state_d = DB_IDLE;
        endcase
        if (dbcc_load) begin
            cnt_d = dbcc_init;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            dcond_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dcond_q <= dcond_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbcc_done   = (state_q == DB_EVAL);
    assign dbcc_branch = branch_d;
    assign dbcc_count  = cnt_q;

`else

    logic dbcc_inputs_unused;

    assign dbcc_inputs_unused = ^{dbcc_load, dbcc_init, dbcc_go, dbcc_cond};
    assign dbcc_done          = 1'b0;
    assign dbcc_branch        = 1'b0;
    assign dbcc_count         = '0;

`endif

endmodule
